// File: rtl/vram_ib_responder.sv
// -----------------------------------------------------------------------------
// vram_ib_responder
//
// Responder end of the internal VRAM bus. Byte-wide CPU requests (ib_*) are
// serviced against a 32-bit synchronous single-port VRAM and return read data
// one cycle after the strobe. Any cycle without a CPU strobe is offered to the
// video fetch client (vf_*) via a level request / single-cycle ack handshake.
// The CPU always wins, so its latency is fixed at one cycle.
//
// Optional feature: define VRAM_IB_STATS_EN to add two saturating 16-bit
// counters (CPU grants, and cycles where video was denied by the CPU).
//
// Parameters:
//   VF_ADDR_W        video fetch word-address width (default 15)
//
// Ports:
//   clk              system clock
//   reset_n          asynchronous active-low reset
//   ib_addr[16:0]    CPU byte address
//   ib_wrdata[7:0]   CPU write byte
//   ib_write         1 = write, 0 = read
//   ib_do_access     single-cycle CPU request strobe
//   ib_rddata[7:0]   CPU read byte, valid the cycle after a read, then held
//   vf_req           video fetch request (level)
//   vf_addr          video fetch word address
//   vf_ack           video grant pulse
//   vf_rddata[31:0]  video read word, held after its valid pulse
//   vf_rddata_valid  one-cycle pulse, the cycle after vf_ack
//   mem_addr[14:0]   VRAM word address
//   mem_wrdata[31:0] VRAM write word (write byte replicated on all lanes)
//   mem_wrbytesel[3:0] VRAM byte write enables
//   mem_write        VRAM write strobe
//   mem_rddata[31:0] VRAM read word, valid one cycle after the address
//   stat_ib_count    (VRAM_IB_STATS_EN) granted CPU strobes, saturating
//   stat_vf_stall    (VRAM_IB_STATS_EN) video-denied cycles, saturating
// -----------------------------------------------------------------------------
module vram_ib_responder #(
  parameter int VF_ADDR_W = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [16:0]          ib_addr,
  input  logic [7:0]           ib_wrdata,
  input  logic                 ib_write,
  input  logic                 ib_do_access,
  output logic [7:0]           ib_rddata,
  input  logic                 vf_req,
  input  logic [VF_ADDR_W-1:0] vf_addr,
  output logic                 vf_ack,
  output logic [31:0]          vf_rddata,
  output logic                 vf_rddata_valid,
  output logic [14:0]          mem_addr,
  output logic [31:0]          mem_wrdata,
  output logic [3:0]           mem_wrbytesel,
  output logic                 mem_write,
  input  logic [31:0]          mem_rddata
`ifdef VRAM_IB_STATS_EN
  ,
  output logic [15:0]          stat_ib_count,
  output logic [15:0]          stat_vf_stall
`endif
);

  // Grants are gated by reset_n so nothing reaches the VRAM while in reset.
  logic        cpu_gnt;
  logic        cpu_wr_gnt;
  logic        cpu_rd_gnt;
  logic        vf_gnt;
  logic [14:0] vf_word_addr;

  assign cpu_gnt    = reset_n & ib_do_access;
  assign cpu_wr_gnt = cpu_gnt & ib_write;
  assign cpu_rd_gnt = cpu_gnt & ~ib_write;
  assign vf_gnt     = reset_n & ~ib_do_access & vf_req;

  // Fit the video address onto the 15-bit VRAM word address.
  if (VF_ADDR_W >= 15) begin : g_vf_trunc
    assign vf_word_addr = vf_addr[14:0];
  end else begin : g_vf_ext
    assign vf_word_addr = {{(15-VF_ADDR_W){1'b0}}, vf_addr};
  end

  // Registered state
  logic [14:0] mem_addr_q;
  logic [14:0] mem_addr_d;
  logic        rd_pend_q;
  logic [1:0]  rd_lane_q;
  logic [7:0]  hold_q;
  logic        vf_pend_q;
  logic [31:0] vf_hold_q;

  // Per-lane write enables/data and read byte extraction.
  logic [7:0] rd_lane_bytes [4];
  logic [7:0] rd_byte;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign mem_wrbytesel[gi]     = cpu_wr_gnt && (ib_addr[1:0] == 2'(gi));
    assign mem_wrdata[8*gi +: 8] = cpu_wr_gnt ? ib_wrdata : 8'h00;
    assign rd_lane_bytes[gi]     = mem_rddata[8*gi +: 8];
  end

  assign rd_byte = rd_lane_bytes[rd_lane_q];

  // Address mux: an idle port keeps the previous address so the VRAM input
  // does not toggle needlessly.
  always_comb begin
    mem_addr_d = mem_addr_q;
    if (cpu_gnt) begin
      mem_addr_d = ib_addr[16:2];
    end else if (vf_gnt) begin
      mem_addr_d = vf_word_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_lane_q  <= 2'd0;
      hold_q     <= 8'h00;
      vf_pend_q  <= 1'b0;
      vf_hold_q  <= '0;
    end else begin
      mem_addr_q <= mem_addr_d;
      rd_pend_q  <= cpu_rd_gnt;
      if (cpu_rd_gnt) begin
        rd_lane_q <= ib_addr[1:0];
      end
      // Capture the returning byte so it stays visible until the next read.
      if (rd_pend_q) begin
        hold_q <= rd_byte;
      end
      vf_pend_q <= vf_gnt;
      if (vf_pend_q) begin
        vf_hold_q <= mem_rddata;
      end
    end
  end

  // Return paths are combinational from the VRAM in the return cycle and
  // fall back to the held copy afterwards.
  assign ib_rddata       = rd_pend_q ? rd_byte : hold_q;
  assign vf_rddata       = vf_pend_q ? mem_rddata : vf_hold_q;
  assign vf_rddata_valid = vf_pend_q;
  assign vf_ack          = vf_gnt;
  assign mem_addr        = mem_addr_d;
  assign mem_write       = cpu_wr_gnt;

`ifdef VRAM_IB_STATS_EN
  logic [15:0] stat_ib_q;
  logic [15:0] stat_stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_ib_q    <= '0;
      stat_stall_q <= '0;
    end else begin
      if (cpu_gnt && (stat_ib_q != 16'hFFFF)) begin
        stat_ib_q <= stat_ib_q + 16'd1;
      end
      if (cpu_gnt && vf_req && (stat_stall_q != 16'hFFFF)) begin
        stat_stall_q <= stat_stall_q + 16'd1;
      end
    end
  end

  assign stat_ib_count = stat_ib_q;
  assign stat_vf_stall = stat_stall_q;
`endif

endmodule
